// File: rtl/apu_shared_dispatch.sv
// Round-robin dispatcher that shares one fixed-latency, fully pipelined FP unit
// between NCPU cores and steers each result back to its issuer through a tag pipeline.
module apu_shared_dispatch #(
  parameter int NCPU     = 8,
  parameter int WARG     = 32,
  parameter int NARGS    = 3,
  parameter int WOP      = 1,
  parameter int NDSFLAGS = 3,
  parameter int NUSFLAGS = 5,
  parameter int LATENCY  = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NCPU-1:0]              core_req_i,
  output logic [NCPU-1:0]              core_gnt_o,
  input  logic [NCPU*NARGS*WARG-1:0]   core_operands_i,
  input  logic [NCPU*WOP-1:0]          core_op_i,
  input  logic [NCPU*NDSFLAGS-1:0]     core_flags_i,
  output logic [NCPU-1:0]              core_rvalid_o,
  output logic [WARG-1:0]              core_result_o,
  output logic [NUSFLAGS-1:0]          core_rflags_o,
  input  logic                         unit_ready_i,
  output logic                         unit_valid_o,
  output logic [NARGS*WARG-1:0]        unit_operands_o,
  output logic [WOP-1:0]               unit_op_o,
  output logic [NDSFLAGS-1:0]          unit_flags_o,
  input  logic [WARG-1:0]              unit_result_i,
  input  logic [NUSFLAGS-1:0]          unit_rflags_i,
  input  logic                         unit_rvalid_i,
  output logic                         tag_error_o
);

  localparam int IDW = $clog2(NCPU);
  localparam int OPW = NARGS * WARG;

  logic [IDW-1:0]      r_ptr;
  logic [LATENCY-1:0]  r_tag_vld;
  logic [IDW-1:0]      r_tag_id [LATENCY];
  logic [NCPU-1:0]     r_rvalid;
  logic [WARG-1:0]     r_result;
  logic [NUSFLAGS-1:0] r_rflags;
  logic                r_tag_err;

  logic [NCPU-1:0]     w_gnt;
  logic [IDW-1:0]      w_gnt_id;
  logic                w_any;
  logic [IDW:0]        w_sum;
  logic [IDW-1:0]      w_idx;
  logic [OPW-1:0]      w_ops;
  logic [WOP-1:0]      w_op;
  logic [NDSFLAGS-1:0] w_fl;
  logic                w_last_vld;
  logic [IDW-1:0]      w_last_id;

  // Arbitration: scan from the pointer, wrapping modulo NCPU, first requester wins
  always_comb begin
    w_gnt    = '0;
    w_gnt_id = '0;
    w_any    = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    if (unit_ready_i) begin
      for (int i = 0; i < NCPU; i++) begin
        w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
        if (w_sum >= (IDW+1)'(NCPU)) w_sum = w_sum - (IDW+1)'(NCPU);
        w_idx = w_sum[IDW-1:0];
        if (!w_any && core_req_i[w_idx]) begin
          w_any    = 1'b1;
          w_gnt_id = w_idx;
        end
      end
    end
    for (int k = 0; k < NCPU; k++) w_gnt[k] = w_any && (w_gnt_id == IDW'(k));
  end

  // Grant is one-hot, so OR-ing the gated slices selects the winner and yields 0 otherwise
  always_comb begin
    w_ops = '0;
    w_op  = '0;
    w_fl  = '0;
    for (int k = 0; k < NCPU; k++) begin
      if (w_gnt[k]) begin
        w_ops = w_ops | core_operands_i[k*OPW +: OPW];
        w_op  = w_op  | core_op_i[k*WOP +: WOP];
        w_fl  = w_fl  | core_flags_i[k*NDSFLAGS +: NDSFLAGS];
      end
    end
  end

  assign w_last_vld = r_tag_vld[LATENCY-1];
  assign w_last_id  = r_tag_id[LATENCY-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr     <= '0;
      r_tag_vld <= '0;
      r_rvalid  <= '0;
      r_result  <= '0;
      r_rflags  <= '0;
      r_tag_err <= 1'b0;
    end else begin
      if (w_any) r_ptr <= (w_gnt_id == IDW'(NCPU-1)) ? '0 : w_gnt_id + 1'b1;
      r_tag_vld[0] <= w_any;
      for (int s = 1; s < LATENCY; s++) r_tag_vld[s] <= r_tag_vld[s-1];
      for (int k = 0; k < NCPU; k++) r_rvalid[k] <= w_last_vld && (w_last_id == IDW'(k));
      if (w_last_vld) begin
        r_result <= unit_result_i;
        r_rflags <= unit_rflags_i;
      end
      if (w_last_vld != unit_rvalid_i) r_tag_err <= 1'b1;
    end
  end

  // Requester IDs are only meaningful alongside their valid bit, so they carry no reset
  always_ff @(posedge clk_i) begin
    r_tag_id[0] <= w_gnt_id;
    for (int s = 1; s < LATENCY; s++) r_tag_id[s] <= r_tag_id[s-1];
  end

  assign core_gnt_o      = w_gnt;
  assign unit_valid_o    = w_any;
  assign unit_operands_o = w_ops;
  assign unit_op_o       = w_op;
  assign unit_flags_o    = w_fl;
  assign core_rvalid_o   = r_rvalid;
  assign core_result_o   = r_result;
  assign core_rflags_o   = r_rflags;
  assign tag_error_o     = r_tag_err;

endmodule

// File: tb/tb_apu_shared_dispatch.sv
// Bench for apu_shared_dispatch: directed and random requests against a cycle-indexed
// reference model of arbitration, the shared unit and result return.
module tb_apu_shared_dispatch;
  localparam int NCPU = 8, WARG = 32, NARGS = 3, WOP = 1, NDS = 3, NUS = 5, LAT = 5;
  localparam int OPW  = NARGS * WARG;
  localparam int MAXC = 2048;

  logic                       clk_i = 1'b0;
  logic                       rst_ni;
  logic [NCPU-1:0]            core_req_i;
  logic [NCPU-1:0]            core_gnt_o;
  logic [NCPU*OPW-1:0]        core_operands_i;
  logic [NCPU*WOP-1:0]        core_op_i;
  logic [NCPU*NDS-1:0]        core_flags_i;
  logic [NCPU-1:0]            core_rvalid_o;
  logic [WARG-1:0]            core_result_o;
  logic [NUS-1:0]             core_rflags_o;
  logic                       unit_ready_i;
  logic                       unit_valid_o;
  logic [OPW-1:0]             unit_operands_o;
  logic [WOP-1:0]             unit_op_o;
  logic [NDS-1:0]             unit_flags_o;
  logic [WARG-1:0]            unit_result_i;
  logic [NUS-1:0]             unit_rflags_i;
  logic                       unit_rvalid_i;
  logic                       tag_error_o;

  apu_shared_dispatch #(
    .NCPU(NCPU), .WARG(WARG), .NARGS(NARGS), .WOP(WOP),
    .NDSFLAGS(NDS), .NUSFLAGS(NUS), .LATENCY(LAT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_operands_i(core_operands_i), .core_op_i(core_op_i), .core_flags_i(core_flags_i),
    .core_rvalid_o(core_rvalid_o), .core_result_o(core_result_o), .core_rflags_o(core_rflags_o),
    .unit_ready_i(unit_ready_i), .unit_valid_o(unit_valid_o),
    .unit_operands_o(unit_operands_o), .unit_op_o(unit_op_o), .unit_flags_o(unit_flags_o),
    .unit_result_i(unit_result_i), .unit_rflags_i(unit_rflags_i), .unit_rvalid_i(unit_rvalid_i),
    .tag_error_o(tag_error_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model state, indexed by absolute cycle number
  int              cyc;
  int              ptr;
  int              last_k;
  bit              err_m;
  logic [NCPU-1:0] rv_m;
  logic [WARG-1:0] res_m;
  logic [NUS-1:0]  fl_m;
  bit              iss_v   [MAXC];
  int              iss_id  [MAXC];
  bit              drv_v   [MAXC];
  logic [WARG-1:0] drv_res [MAXC];
  logic [NUS-1:0]  drv_fl  [MAXC];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  // Behaviour of the shared unit: some fixed function of what the issuing core sent
  function automatic logic [WARG-1:0] unit_res(input int k);
    logic [OPW-1:0] o;
    o = core_operands_i[k*OPW +: OPW];
    return (o[31:0] + o[63:32] + o[95:64]) ^ WARG'(core_op_i[k]);
  endfunction

  function automatic logic [NUS-1:0] unit_fl(input int k);
    return {core_flags_i[k*NDS +: NDS], core_op_i[k], 1'b1};
  endfunction

  task automatic rand_data();
    for (int i = 0; i < NCPU*NARGS; i++) core_operands_i[i*WARG +: WARG] = $urandom;
    core_op_i    = (NCPU*WOP)'($urandom);
    core_flags_i = (NCPU*NDS)'($urandom);
  endtask

  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      iss_v[i] = 1'b0;
      drv_v[i] = 1'b0;
    end
    ptr = 0; err_m = 1'b0; rv_m = '0; res_m = '0; fl_m = '0;
  endtask

  // Reset with requests dropped, as the cores reset alongside this block
  task automatic do_reset();
    core_req_i = '0; unit_ready_i = 1'b0; unit_rvalid_i = 1'b0;
    unit_result_i = '0; unit_rflags_i = '0;
    rst_ni = 1'b0;
    #1;
    chk("rst_gnt", core_gnt_o, '0);
    chk("rst_uvalid", unit_valid_o, 1'b0);
    chk("rst_rvalid", core_rvalid_o, '0);
    chk("rst_result", core_result_o, '0);
    chk("rst_rflags", core_rflags_o, '0);
    chk("rst_tagerr", tag_error_o, 1'b0);
    clear_model();
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cyc += 3;
  endtask

  // One clock: drive the unit, check against the model, then advance the model
  task automatic do_cycle();
    int k;
    bit last;
    logic [NCPU-1:0] g_exp;
    unit_rvalid_i = drv_v[cyc];
    unit_result_i = drv_v[cyc] ? drv_res[cyc] : WARG'($urandom);
    unit_rflags_i = drv_v[cyc] ? drv_fl[cyc]  : NUS'($urandom);
    k = -1;
    if (unit_ready_i)
      for (int i = 0; i < NCPU; i++)
        if (k < 0 && core_req_i[(ptr + i) % NCPU]) k = (ptr + i) % NCPU;
    @(negedge clk_i);
    g_exp = (k >= 0) ? (NCPU'(1) << k) : '0;
    chk("gnt", core_gnt_o, g_exp);
    chk("uvalid", unit_valid_o, k >= 0);
    chk("uops", unit_operands_o, (k >= 0) ? core_operands_i[k*OPW +: OPW] : '0);
    chk("uop", unit_op_o, (k >= 0) ? core_op_i[k*WOP +: WOP] : '0);
    chk("uflags", unit_flags_o, (k >= 0) ? core_flags_i[k*NDS +: NDS] : '0);
    chk("rvalid", core_rvalid_o, rv_m);
    chk("result", core_result_o, res_m);
    chk("rflags", core_rflags_o, fl_m);
    chk("tagerr", tag_error_o, err_m);
    last_k = k;
    if (k >= 0) begin
      ptr = (k + 1) % NCPU;
      iss_v[cyc] = 1'b1; iss_id[cyc] = k;
      drv_v[cyc+LAT] = 1'b1;
      drv_res[cyc+LAT] = unit_res(k);
      drv_fl[cyc+LAT] = unit_fl(k);
    end
    last = (cyc >= LAT) && iss_v[cyc-LAT];
    if (last) begin
      rv_m = NCPU'(1) << iss_id[cyc-LAT];
      res_m = unit_result_i;
      fl_m = unit_rflags_i;
    end else begin
      rv_m = '0;
    end
    if (last != unit_rvalid_i) err_m = 1'b1;
    @(posedge clk_i); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    core_req_i = '0;
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  initial begin
    cyc = 0;
    rst_ni = 1'b0;
    core_req_i = '0; unit_ready_i = 1'b0;
    core_operands_i = '0; core_op_i = '0; core_flags_i = '0;
    unit_rvalid_i = 1'b0; unit_result_i = '0; unit_rflags_i = '0;
    do_reset();
    idle(2);

    // Single request from core 3
    rand_data();
    unit_ready_i = 1'b1;
    core_req_i = 8'h08;
    do_cycle();
    idle(LAT + 3);

    // All cores requesting continuously from reset: grants 0..7,0,1
    do_reset();
    unit_ready_i = 1'b1;
    core_req_i = '1;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      do_cycle();
    end
    idle(LAT + 3);

    // Reset with three operations still in flight
    core_req_i = 8'h91;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      do_cycle();
      core_req_i[last_k] = 1'b0;
    end
    idle(1);
    do_reset();
    idle(LAT + 3);

    // Unit stalled for three cycles with cores 2 and 5 waiting
    unit_ready_i = 1'b0;
    core_req_i = 8'h24;
    for (int i = 0; i < 3; i++) do_cycle();
    unit_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      do_cycle();
      if (last_k >= 0) core_req_i[last_k] = 1'b0;
    end
    idle(LAT + 3);

    // Back-to-back grants to cores 1, 6, 1
    core_req_i = 8'h02; rand_data(); do_cycle();
    core_req_i = 8'h40; rand_data(); do_cycle();
    core_req_i = 8'h02; rand_data(); do_cycle();
    idle(LAT + 3);

    // Random traffic; a core holds its request until granted
    core_req_i = '0;
    for (int i = 0; i < 300; i++) begin
      rand_data();
      unit_ready_i = ($urandom_range(0, 3) != 0);
      core_req_i = core_req_i | NCPU'($urandom) & NCPU'($urandom);
      do_cycle();
      if (last_k >= 0) core_req_i[last_k] = 1'b0;
    end
    idle(LAT + 3);

    // Spurious unit result with the tag pipeline empty
    drv_v[cyc] = 1'b1;
    drv_res[cyc] = 32'hDEAD_BEEF;
    drv_fl[cyc] = 5'h15;
    idle(4);
    do_reset();
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
